// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int DEF_DEPTH   = 2;
  localparam int DEF_TIMEOUT = 255;

  // Fetch FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] KILL = 2'd2;

  // One buffered fetch result: where it came from and what came back
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO holding completed fetches for the decode stage.
// Flush empties the FIFO and wins over a same-cycle pop or push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic [PW:0]  count_o,
  output logic         full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ~full_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one memory request at a time from PCResult,
// buffers returned words for decode and tells the PC register when to move.
// Optional macro FETCH_TIMEOUT_EN adds a sticky wait-timeout flag (FetchErr).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  PCResult,
  input  logic               Redirect,
  input  logic               DecodeReady,
  output logic               MemReq,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic               MemAck,
  input  logic [INSTR_W-1:0] MemRdata,
  output logic               NotStall,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               FetchErr
);

  localparam int PW = $clog2(DEPTH);

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push, pop, full;
  logic [PW:0]       count;
  fetch_entry_t      head, wentry;

  // Only a live (non-killed) request completing without a redirect is kept
  assign push     = (state_q == REQ) & MemAck & ~Redirect;
  assign pop      = InstrValid & DecodeReady & ~Redirect;
  assign NotStall = Reset & (Redirect | push);
  assign wentry   = '{pc: addr_q, instr: MemRdata};

  assign MemReq      = req_q;
  assign MemAddr     = addr_q;
  assign InstrValid  = (count != '0);
  assign Instruction = head.instr;
  assign InstrPC     = head.pc;

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (Redirect),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  // Next state: the memory request can never be withdrawn, so a redirect
  // mid-request parks in KILL until the ack drains it.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (!full && !Redirect) begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = PCResult;
      end
      REQ: if (MemAck) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end else if (Redirect) begin
        state_d = KILL;
      end
      KILL: if (MemAck) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM and memory-side request registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          enter_wait;

  // Counter restarts whenever a new REQ or KILL phase begins
  assign enter_wait = (state_d != state_q) && (state_d != IDLE);
  assign FetchErr   = err_q;

  // Saturating wait counter; the flag is sticky until reset
  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if (enter_wait) begin
      wait_d = '0;
    end else if (req_q && !MemAck && (wait_q != '1)) begin
      wait_d = wait_q + WW'(1);
      if (wait_d >= WW'(TIMEOUT)) err_d = 1'b1;
    end
  end

  // Timeout state registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  // TIMEOUT only matters when the timeout check is built in
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign FetchErr       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes hand-computed
// {pc, instr} expectations; a monitor pops and compares on every decode pop.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Redirect = 1'b0;
  logic        DecodeReady = 1'b0;
  logic        MemAck = 1'b0;
  logic [31:0] MemRdata = '0;
  logic [31:0] PCResult, MemAddr, Instruction, InstrPC;
  logic        MemReq, NotStall, InstrValid, FetchErr;

`ifdef FETCH_TIMEOUT_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 Clk = ~Clk;

  fetch_unit #(.DEPTH(2), .TIMEOUT(10)) dut (
    .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Redirect(Redirect),
    .DecodeReady(DecodeReady), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemRdata(MemRdata), .NotStall(NotStall),
    .InstrValid(InstrValid), .Instruction(Instruction), .InstrPC(InstrPC),
    .FetchErr(FetchErr)
  );

  // PC register: advance by 4 or load target when enabled
  logic [31:0] pc_q, tgt = '0;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset)        pc_q <= '0;
    else if (NotStall) pc_q <= Redirect ? tgt : pc_q + 32'd4;
  assign PCResult = pc_q;

  // Instruction memory: ack after ack_delay waiting cycles
  int ack_delay = 0;
  int wcnt = 0;
  bit spurious = 1'b0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h8C09_0004;
      32'h8:   return 32'h0109_5020;
      32'h200: return 32'h0085_1020;
      default: return 32'hDEAD_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  always begin
    @(posedge Clk); #1;
    if (!Reset) begin
      MemAck = 1'b0; wcnt = 0;
    end else if (MemReq) begin
      if (wcnt >= ack_delay) begin
        MemAck = 1'b1; MemRdata = memdata(MemAddr);
      end else begin
        MemAck = 1'b0; wcnt++;
      end
    end else begin
      MemAck = spurious; MemRdata = 32'hFFFF_FFFF; wcnt = 0;
    end
  end

  // Scoreboard
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back('{pc: pc, ins: ins});
  endtask

  // Monitor: every accepted decode pop must match the next expectation
  always @(negedge Clk) begin
    if (Reset === 1'b1 && InstrValid === 1'b1 && DecodeReady && !Redirect) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_extra: got pc %h ins %h want none", InstrPC, Instruction);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", InstrPC, mon_e.pc);
        check("sb_ins", Instruction, mon_e.ins);
      end
    end
  end

  task automatic cyc(); @(posedge Clk); #2; endtask
  task automatic neg(); @(negedge Clk); endtask

  // Reset for two edges, release; returns in cycle 0 after release
  task automatic start();
    cyc();
    Reset = 1'b0; Redirect = 1'b0; spurious = 1'b0;
    check("sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cyc(); cyc();
    Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cyc(); neg();
    check("rst_req", MemReq, 0);
    check("rst_addr", MemAddr, 0);
    check("rst_valid", InstrValid, 0);
    check("rst_ins", Instruction, 0);
    check("rst_ipc", InstrPC, 0);
    check("rst_ns", NotStall, 0);
    check("rst_err", FetchErr, 0);
    Redirect = 1'b1; #1;
    check("rst_ns_redir", NotStall, 0);
    Redirect = 1'b0;

    // Basic fetch, ack on the 4th REQ cycle
    start(); ack_delay = 3; DecodeReady = 1'b1;
    push_exp(32'h0, 32'h2008_0005);
    neg(); check("B_idle_req", MemReq, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); neg();
      check("B_req", MemReq, 1);
      check("B_addr", MemAddr, 0);
      check("B_ns_wait", NotStall, 0);
    end
    cyc(); neg(); check("B_ns_ack", NotStall, 1);
    cyc(); neg();
    check("B_valid", InstrValid, 1);
    check("B_ins", Instruction, 32'h2008_0005);
    check("B_ipc", InstrPC, 0);
    check("B_ns_after", NotStall, 0);

    // Reset asserted mid-request with one buffered entry
    start(); ack_delay = 0; DecodeReady = 1'b0;
    cyc(); ack_delay = 5; neg(); check("A_ns_ack", NotStall, 1);
    cyc(); neg(); check("A_valid1", InstrValid, 1);
    cyc(); neg();
    check("A_req_pre", MemReq, 1);
    check("A_addr_pre", MemAddr, 32'h4);
    #1 Reset = 1'b0; Redirect = 1'b1;
    #1;
    check("A_req_rst", MemReq, 0);
    check("A_valid_rst", InstrValid, 0);
    check("A_ns_rst", NotStall, 0);
    check("A_addr_rst", MemAddr, 0);
    check("A_ins_rst", Instruction, 0);
    Redirect = 1'b0;
    cyc(); Reset = 1'b1;
    cyc(); neg();
    check("A_req_rel", MemReq, 1);
    check("A_addr_rel", MemAddr, 0);

    // Fill with decode stalled, then single pops
    start(); ack_delay = 0; DecodeReady = 1'b0;
    push_exp(32'h0, 32'h2008_0005);
    push_exp(32'h4, 32'h8C09_0004);
    push_exp(32'h8, 32'h0109_5020);
    cyc(); neg(); check("C_ns1", NotStall, 1); check("C_addr1", MemAddr, 0);
    cyc(); neg(); check("C_ns_gap", NotStall, 0); check("C_valid", InstrValid, 1);
    cyc(); neg(); check("C_ns2", NotStall, 1); check("C_addr2", MemAddr, 32'h4);
    for (int k = 4; k <= 6; k++) begin
      cyc(); neg();
      check("C_full_req", MemReq, 0);
      check("C_full_ns", NotStall, 0);
    end
    cyc(); DecodeReady = 1'b1; neg(); check("C_req_pop", MemReq, 0);
    cyc(); DecodeReady = 1'b0; neg();
    check("C_ipc_after", InstrPC, 32'h4);
    check("C_req_after", MemReq, 0);
    cyc(); neg();
    check("C_req3", MemReq, 1);
    check("C_addr3", MemAddr, 32'h8);
    check("C_ns3", NotStall, 1);
    cyc(); DecodeReady = 1'b1; neg();
    cyc(); neg(); check("C_ipc_last", InstrPC, 32'h8);
    cyc(); DecodeReady = 1'b0;

    // Redirect during REQ, then again during KILL
    start(); ack_delay = 3; DecodeReady = 1'b1; tgt = 32'h100;
    cyc(); Redirect = 1'b1; neg();
    check("D_ns_redir", NotStall, 1); check("D_req", MemReq, 1);
    cyc(); Redirect = 1'b0; neg();
    check("D_ns_kill", NotStall, 0);
    check("D_req_kill", MemReq, 1);
    check("D_addr_kill", MemAddr, 0);
    check("D_valid_kill", InstrValid, 0);
    cyc(); Redirect = 1'b1; tgt = 32'h200; neg();
    check("D_ns_redir2", NotStall, 1);
    cyc(); Redirect = 1'b0; neg();
    check("D_ns_killack", NotStall, 0);
    check("D_valid_killack", InstrValid, 0);
    cyc(); ack_delay = 0; neg();
    check("D_req_idle", MemReq, 0);
    check("D_valid_idle", InstrValid, 0);
    push_exp(32'h200, 32'h0085_1020);
    cyc(); neg();
    check("D_req_tgt", MemReq, 1);
    check("D_addr_tgt", MemAddr, 32'h200);
    check("D_ns_tgt", NotStall, 1);
    cyc(); neg(); check("D_valid_tgt", InstrValid, 1);

    // Redirect together with ack and decode-ready; stray ack while idle
    start(); ack_delay = 0; DecodeReady = 1'b0; tgt = 32'h40;
    cyc(); neg(); check("E_ns1", NotStall, 1);
    cyc(); neg(); check("E_valid1", InstrValid, 1);
    cyc(); Redirect = 1'b1; DecodeReady = 1'b1; spurious = 1'b1; neg();
    check("E_ns_redir", NotStall, 1);
    check("E_addr", MemAddr, 32'h4);
    check("E_valid_pre", InstrValid, 1);
    cyc(); Redirect = 1'b0; DecodeReady = 1'b0; spurious = 1'b0; ack_delay = 7; neg();
    check("E_valid_flush", InstrValid, 0);
    check("E_req_idle", MemReq, 0);
    check("E_ns_stray", NotStall, 0);
    cyc(); neg();
    check("E_req_tgt", MemReq, 1);
    check("E_addr_tgt", MemAddr, 32'h40);
    check("E_valid_tgt", InstrValid, 0);

    // Long wait: FetchErr behaviour with TIMEOUT=10
    start(); ack_delay = 20; DecodeReady = 1'b1;
    push_exp(32'h0, 32'h2008_0005);
    for (int k = 1; k <= 22; k++) begin
      cyc(); neg();
      if (k == 10) check("F_err_before", FetchErr, 0);
      if (k == 11) check("F_err_at", FetchErr, EXP_ERR);
      if (k == 21) check("F_ns_ack", NotStall, 1);
      if (k == 22) begin
        check("F_err_after", FetchErr, EXP_ERR);
        check("F_valid", InstrValid, 1);
      end
    end

    cyc();
    check("sb_left_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer end of the PC register's fetch interface: takes PCResult, fetches the instruction from a multi-cycle instruction memory with a req/ack handshake, and buffers it for the ID stage.
- Drives NotStall back to the PC register. The PC advances only when a fetch completes, or when a redirect (branch/jump) occurs.
- Sits between the PC register, instruction memory and IF/ID pipeline register.

Parameters:
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- TIMEOUT, 255, max cycles MemReq may wait for MemAck (used only with optional feature)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  asynchronous, active-low reset (Reset==0 resets)
- PCResult  in  32  current PC register value
- Redirect  in  1  branch/jump taken; flush fetch path, PC loads target
- DecodeReady  in  1  ID stage accepts buffer head this cycle
- MemReq  out  1  instruction memory request (registered)
- MemAddr  out  32  request address, stable while MemReq=1
- MemAck  in  1  memory completes request; MemRdata valid this cycle
- MemRdata  in  32  instruction word
- NotStall  out  1  PC write enable (combinational)
- InstrValid  out  1  buffer head valid
- Instruction  out  32  buffer head instruction
- InstrPC  out  32  PC of buffer head
- FetchErr  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- States: IDLE, REQ, KILL.
- Reset: state IDLE; MemReq=0; MemAddr=0; buffer count=0; InstrValid=0; Instruction=0; InstrPC=0; FetchErr=0. NotStall=0 under reset.
- IDLE→REQ when count<DEPTH and Redirect=0. Same edge: MemAddr<=PCResult, MemReq<=1.
- REQ: MemReq held at 1 and MemAddr held stable until MemAck. No abort is allowed on the memory side.
  - On MemAck with Redirect=0: push {MemAddr, MemRdata}; NotStall=1 this cycle; MemReq<=0; →IDLE.
  - Minimum throughput: 1 instruction per 2 cycles. Minimum latency: ack in first REQ cycle gives InstrValid the next cycle.
- Redirect=1 in any state:
  - NotStall=1 that cycle.
  - Buffer flushed (count<=0); flush overrides a simultaneous pop.
  - In REQ without MemAck: →KILL.
  - In REQ with MemAck: data discarded, →IDLE.
- KILL: MemReq held until MemAck. Data discarded, no NotStall from the ack, →IDLE. Further Redirect in KILL: NotStall=1, stay KILL.
- NotStall=0 in every other cycle.
- Buffer:
  - FIFO with wrapping pointers (log2 DEPTH bits).
  - InstrValid=(count!=0); Instruction/InstrPC = head entry.
  - Pop when InstrValid & DecodeReady & !Redirect.
  - Push and pop in the same cycle: count unchanged.
  - A request is issued only when count<DEPTH and only one request is outstanding, so overflow is impossible.
  - Pop on empty is ignored.
- MemAck while MemReq=0: ignored.
- Reset asserted mid-request: everything returns to reset values immediately. The memory side must also be reset.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - 8-bit+ wait counter clears on entry to REQ/KILL and increments each cycle MemReq=1 without MemAck.
  - Reaching TIMEOUT sets FetchErr=1 (sticky until Reset). The request stays asserted, so the protocol is unchanged.
- Undefined: no counter; FetchErr tied 0.

Decomposition:
- Package fetch_pkg holds:
  - state encoding constants IDLE=2'd0, REQ=2'd1, KILL=2'd2
  - INSTR_W=32, ADDR_W=32
  - default DEPTH and TIMEOUT
- Sub-module fetch_buffer: parameterised FIFO with push, pop, flush, count, full and head data. The FSM and handshake stay in fetch_unit.

Test Plan:
- Reset low mid-REQ with count=1 → MemReq=0, InstrValid=0, NotStall=0 same cycle. After release, first request has MemAddr=PCResult=0x00000000.
- PCResult=0x0, MemAck 3 cycles after MemReq, MemRdata=0x20080005, DecodeReady=1 → NotStall=1 for exactly the ack cycle. Next cycle: InstrValid=1, Instruction=0x20080005, InstrPC=0x0.
- DecodeReady=0, zero-wait memory, DEPTH=2 → two pushes (PC 0x0, 0x4), then MemReq stays 0 and NotStall stays 0. DecodeReady=1 for one cycle → new request issues at PC 0x8.
- Redirect during REQ (ack 2 cycles later) → NotStall=1 on the redirect cycle only, buffer empty, state KILL. Ack data discarded, InstrValid stays 0, next MemAddr = target PC.
- Redirect same cycle as MemAck and DecodeReady with count=1 → data dropped, count=0, InstrValid=0 next cycle.
- FETCH_TIMEOUT_EN, TIMEOUT=10, MemAck withheld → FetchErr=1 after 10 waiting cycles and stays 1 after ack. Compiled out → FetchErr=0 throughout.
